// File: rtl/dct_pkg.sv
// Shared constants and types for the 8-point DCT datapath (row pass, transpose, column pass).
package dct_pkg;

  localparam int unsigned DCT_N          = 8;
  localparam int unsigned IDX_W          = 3;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned VEC_WIDTH      = DCT_N * DEF_DATA_WIDTH;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_N - 1);

  typedef logic [DEF_DATA_WIDTH-1:0] dct_elem_t;
  typedef logic [VEC_WIDTH-1:0]      dct_vec_t;

  // Modulo-8 increment used by the row/column pointers.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/dct_transpose_8x8_if.sv
// Row-in / column-out handshake bundle of the 8x8 transpose buffer.
interface dct_transpose_8x8_if #(
  parameter int unsigned DATA_WIDTH = dct_pkg::DEF_DATA_WIDTH
);
  import dct_pkg::*;

  localparam int unsigned VW = DCT_N * DATA_WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [VW-1:0]    row_in;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    col_out;
  logic [IDX_W-1:0] col_idx;
  logic             col_last;

  // Environment side: produces rows, consumes columns.
  modport master (
    output in_valid, row_in, out_ready,
    input  in_ready, out_valid, col_out, col_idx, col_last
  );

  // Buffer side.
  modport slave (
    input  in_valid, row_in, out_ready,
    output in_ready, out_valid, col_out, col_idx, col_last
  );

endinterface

// File: rtl/dct_tp_bank.sv
// One 8x8 register bank: row-wide write port, combinational column-wide read port.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_row,
  input  logic [DCT_N*DATA_WIDTH-1:0] wr_vec,
  input  logic [IDX_W-1:0]            rd_col,
  output logic [DCT_N*DATA_WIDTH-1:0] rd_vec
);

  localparam int unsigned VW = DCT_N * DATA_WIDTH;

  logic [DCT_N-1:0][VW-1:0] mem_q;
  logic [DCT_N-1:0][VW-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_row] = wr_vec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Gather element rd_col from every stored row: this is the transpose.
  always_comb begin
    rd_vec = '0;
    for (int r = 0; r < int'(DCT_N); r++) begin
      rd_vec[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][int'(rd_col)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D DCTs.
module dct_transpose_8x8
  import dct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  dct_transpose_8x8_if.slave  bus
);

  localparam int unsigned VW = DCT_N * DATA_WIDTH;

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_cnt_q,  wr_cnt_d;
  logic [IDX_W-1:0] rd_cnt_q,  rd_cnt_d;
  logic [1:0]       full_q,    full_d;

  logic             wr_fire;
  logic             rd_fire;
  logic [1:0]       bank_we;
  logic [VW-1:0]    bank_col [2];

  assign wr_fire = bus.in_valid && !full_q[wr_bank_q];
  assign rd_fire = full_q[rd_bank_q] && bus.out_ready;
  assign bank_we = {wr_fire && wr_bank_q, wr_fire && !wr_bank_q};

  // A bank becomes readable only once all 8 rows are in, so partial blocks stay hidden.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;

    if (wr_fire) begin
      wr_cnt_d = idx_inc(wr_cnt_q);
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    if (rd_fire) begin
      rd_cnt_d = idx_inc(rd_cnt_q);
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (bank_we[b]),
      .wr_row  (wr_cnt_q),
      .wr_vec  (bus.row_in),
      .rd_col  (rd_cnt_q),
      .rd_vec  (bank_col[b])
    );
  end

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.col_out   = bank_col[rd_bank_q];
  assign bus.col_idx   = rd_cnt_q;
  assign bus.col_last  = full_q[rd_bank_q] && (rd_cnt_q == LAST_IDX);

  // A write only targets a non-full bank and a read only a full one, so they never collide.
  a_no_bank_clash : assert property (
    @(posedge clk) disable iff (!reset_n) (wr_fire && rd_fire) |-> (wr_bank_q != rd_bank_q)
  );

endmodule

// File: tb/tb_dct_transpose_8x8.sv
// Directed and random-handshake bench for the 8x8 transpose buffer, checked against a block-queue model.
module tb_dct_transpose_8x8;
  import dct_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned VW = DCT_N * DW;

  typedef logic [DCT_N-1:0][VW-1:0] blk_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dct_transpose_8x8_if #(.DATA_WIDTH(DW)) bus ();

  dct_transpose_8x8 #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  blk_t mq[$];
  blk_t cur;
  int   mwr = 0;
  int   mrd = 0;
  int   feed_blk = 0;
  int   blocks_in = 0;
  int   blocks_out = 0;
  int   cols_seen = 0;

  task automatic check_val(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk_row(input int b, input int r);
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < int'(DCT_N); c++) begin
      v[c*DW +: DW] = {24'(b), 4'(r), 4'(c)};
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] col_of(input blk_t b, input int c);
    logic [VW-1:0] v;
    v = '0;
    for (int r = 0; r < int'(DCT_N); r++) begin
      v[r*DW +: DW] = b[r][c*DW +: DW];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] w(input int x);
    return VW'(x);
  endfunction

  function automatic void model_clear();
    mq.delete();
    mwr = 0;
    mrd = 0;
  endfunction

  // One clock: drive at the falling edge, check outputs against the model, advance the model.
  task automatic cycle(input logic iv, input logic ordy);
    bit mi;
    bit mo;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.row_in    = mk_row(feed_blk, mwr);
    #1;
    mi = iv && (mq.size() < 2);
    mo = ordy && (mq.size() > 0);
    check_val("in_ready", w(int'(bus.in_ready)), w(int'(mq.size() < 2)));
    check_val("out_valid", w(int'(bus.out_valid)), w(int'(mq.size() > 0)));
    if (mq.size() > 0) begin
      check_val("col_out", bus.col_out, col_of(mq[0], mrd));
      check_val("col_idx", w(int'(bus.col_idx)), w(mrd));
    end
    check_val("col_last", w(int'(bus.col_last)), w(int'((mq.size() > 0) && (mrd == 7))));
    @(posedge clk);
    if (mo) begin
      cols_seen++;
      if (mrd == 7) begin
        void'(mq.pop_front());
        blocks_out++;
        mrd = 0;
      end else begin
        mrd++;
      end
    end
    if (mi) begin
      cur[mwr] = mk_row(feed_blk, mwr);
      if (mwr == 7) begin
        mq.push_back(cur);
        blocks_in++;
        feed_blk++;
        mwr = 0;
      end else begin
        mwr++;
      end
    end
    @(negedge clk);
  endtask

  task automatic hold_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.row_in    = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int stalls;
    int cols0;
    int acc;
    int target;
    int n;

    // Reset values
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.row_in    = '0;
    @(negedge clk);
    hold_reset();
    check_val("rst_in_ready", w(int'(bus.in_ready)), w(1));
    check_val("rst_out_valid", w(int'(bus.out_valid)), w(0));
    check_val("rst_col_out", bus.col_out, '0);
    check_val("rst_col_idx", w(int'(bus.col_idx)), w(0));
    check_val("rst_col_last", w(int'(bus.col_last)), w(0));

    // Single block, element (r,c) = 0x000000rc
    feed_blk = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    check_val("lat_valid", w(int'(bus.out_valid)), w(1));
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        check_val("col3_r2", w(int'(bus.col_out[2*DW +: DW])), w(32'h0000_0023));
        check_val("col3_r7", w(int'(bus.col_out[7*DW +: DW])), w(32'h0000_0073));
      end
      check_val("col_last_hand", w(int'(bus.col_last)), w(int'(c == 7)));
      cycle(1'b0, 1'b1);
    end
    check_val("single_done", w(int'(bus.out_valid)), w(0));

    // Back-to-back: 4 blocks, 32 consecutive columns
    stalls = 0;
    cols0  = cols_seen;
    for (int i = 0; i < 40; i++) begin
      if (i < 32 && !bus.in_ready) stalls++;
      cycle(1'(i < 32), 1'b1);
    end
    check_val("b2b_stalls", w(stalls), w(0));
    check_val("b2b_cols", w(cols_seen - cols0), w(32));

    // Backpressure: out_ready low while 20 rows are offered
    feed_blk = 0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) acc++;
      cycle(1'b1, 1'b0);
    end
    check_val("bp_accepts", w(acc), w(16));
    check_val("bp_in_ready", w(int'(bus.in_ready)), w(0));
    check_val("bp_hold", w(int'(bus.col_out[1*DW +: DW])), w(32'h0000_0010));
    for (int c = 0; c < 8; c++) begin
      if (c == 7) check_val("bp_ready_low", w(int'(bus.in_ready)), w(0));
      cycle(1'b1, 1'b1);
    end
    check_val("bp_ready_back", w(int'(bus.in_ready)), w(1));
    n = 0;
    while ((mq.size() > 0 || mwr != 0) && n < 200) begin
      cycle(1'(mwr != 0), 1'b1);
      n++;
    end
    check_val("bp_drained", w(mq.size() + mwr), w(0));

    // Random handshake over 64 blocks
    target = blocks_in + 64;
    cols0  = cols_seen;
    n = 0;
    while (blocks_out < target && n < 20000) begin
      cycle(1'((blocks_in < target) && ($urandom_range(0, 1) == 1)), 1'($urandom_range(0, 1)));
      n++;
    end
    check_val("rand_blocks", w(blocks_out), w(target));
    check_val("rand_cols", w(cols_seen - cols0), w(512));

    // Reset mid-block while the previous block drains
    feed_blk = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", w(int'(bus.out_valid)), w(0));
    check_val("mid_rst_ready", w(int'(bus.in_ready)), w(1));
    check_val("mid_rst_col", bus.col_out, '0);
    check_val("mid_rst_idx", w(int'(bus.col_idx)), w(0));
    @(negedge clk);
    hold_reset();
    feed_blk = 7;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    check_val("post_rst_r4", w(int'(bus.col_out[4*DW +: DW])), w(32'h0000_0740));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
    check_val("post_rst_done", w(int'(bus.out_valid)), w(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
